// File: rtl/fb_access_arbiter.sv
// Frame buffer port arbiter: the scan-out read always wins, and two pixel writers
// share the remaining cycles round-robin. An optional gate holds writes until vblank.
module fb_access_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 307200
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              gate_en_i,
    input  logic              vblank_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_valid_o,
    input  logic              wr0_req_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    output logic              wr0_gnt_o,
    input  logic              wr1_req_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic              wr1_gnt_o,
    output logic              wr_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

    logic              gate_open;
    logic              wr0_elig;
    logic              wr1_elig;
    logic              pick_wr1;
    logic              wr_any;
    logic              win_in_range;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              rr_last_q;  // 1: wr1 was granted last
    logic              rr_last_d;
    logic              rd_s2_q;

    logic              mem_en_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              gnt0_d;
    logic              gnt1_d;
    logic              err_d;

    always_comb begin
        gate_open    = !gate_en_i || vblank_i;
        wr0_elig     = !disp_req_i && wr0_req_i && gate_open;
        wr1_elig     = !disp_req_i && wr1_req_i && gate_open;
        pick_wr1     = wr1_elig && (!wr0_elig || !rr_last_q);
        wr_any       = wr0_elig || wr1_elig;
        win_addr     = pick_wr1 ? wr1_addr_i : wr0_addr_i;
        win_data     = pick_wr1 ? wr1_data_i : wr0_data_i;
        win_in_range = {1'b0, win_addr} < DepthExt;
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        err_d       = 1'b0;
        rr_last_d   = rr_last_q;
        if (disp_req_i) begin
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr_i;
        end else if (wr_any) begin
            // An out-of-range write is still granted so the writer moves on,
            // but the RAM is left untouched.
            mem_en_d    = win_in_range;
            mem_we_d    = win_in_range;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_data;
            gnt0_d      = !pick_wr1;
            gnt1_d      = pick_wr1;
            err_d       = !win_in_range;
            rr_last_d   = pick_wr1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            wr0_gnt_o    <= 1'b0;
            wr1_gnt_o    <= 1'b0;
            wr_err_o     <= 1'b0;
            rr_last_q    <= 1'b1;
            rd_s2_q      <= 1'b0;
            disp_valid_o <= 1'b0;
            disp_data_o  <= '0;
        end else begin
            mem_en_o     <= mem_en_d;
            mem_we_o     <= mem_we_d;
            mem_addr_o   <= mem_addr_d;
            mem_wdata_o  <= mem_wdata_d;
            wr0_gnt_o    <= gnt0_d;
            wr1_gnt_o    <= gnt1_d;
            wr_err_o     <= err_d;
            rr_last_q    <= rr_last_d;
            // RAM data for the read issued last cycle is on mem_rdata_i now.
            rd_s2_q      <= mem_en_o && !mem_we_o;
            disp_valid_o <= rd_s2_q;
            if (rd_s2_q) begin
                disp_data_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter with a behavioural single-port RAM.
module tb_fb_access_arbiter;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 3;
    localparam int unsigned DEPTH  = 307200;

    logic              clk = 1'b0;
    logic              rst;
    logic              gate_en;
    logic              vblank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr0_req;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_gnt;
    logic              wr1_req;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_gnt;
    logic              wr_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              preload = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic [DATA_W-1:0] ram [0:(1 << ADDR_W) - 1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) ram[i] <= DATA_W'(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    fb_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .gate_en_i(gate_en), .vblank_i(vblank),
        .disp_req_i(disp_req), .disp_addr_i(disp_addr),
        .disp_data_o(disp_data), .disp_valid_o(disp_valid),
        .wr0_req_i(wr0_req), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr0_gnt_o(wr0_gnt),
        .wr1_req_i(wr1_req), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .wr1_gnt_o(wr1_gnt), .wr_err_o(wr_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic set_idle();
        gate_en = 1'b0; vblank = 1'b0; disp_req = 1'b0; disp_addr = '0;
        wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    endtask

    task automatic test_reset();
        logic [2*ADDR_W+2*DATA_W+6:0] outs;
        rst = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        outs = {disp_data, disp_valid, wr0_gnt, wr1_gnt, wr_err, mem_en, mem_we,
                mem_addr, mem_wdata, {ADDR_W{1'b0}}};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_power_on: outputs %0h, expected 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 19'd1;
        wr0_req = 1'b1; wr0_addr = 19'd10; wr0_data = 3'd1;
        wr1_req = 1'b1; wr1_addr = 19'd11; wr1_data = 3'd2;
        @(negedge clk);
        disp_addr = 19'd2;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            outs = {disp_data, disp_valid, wr0_gnt, wr1_gnt, wr_err, mem_en, mem_we,
                    mem_addr, mem_wdata, {ADDR_W{1'b0}}};
            n_checks++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL reset_mid_op[%0d]: outputs %0h, expected 0", c, outs);
            end
        end
        rst = 1'b0; disp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr0_gnt !== 1'b1 || wr1_gnt !== 1'b0 || mem_addr !== 19'd10 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_tie: gnt0=%b gnt1=%b addr=%0d we=%b, expected 1 0 10 1",
                     wr0_gnt, wr1_gnt, mem_addr, mem_we);
        end
        set_idle();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (disp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_read_flush[%0d]: disp_valid=%b, expected 0", c, disp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_read_latency();
        logic exp_v;
        logic [DATA_W-1:0] exp_d;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                n_checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(c - 1)) begin
                    n_fail++;
                    $display("FAIL read_mem_issue[%0d]: en=%b we=%b addr=%0d, expected 1 0 %0d",
                             c, mem_en, mem_we, mem_addr, c - 1);
                end
            end
            exp_v = (c >= 3 && c <= 10);
            n_checks++;
            if (disp_valid !== exp_v) begin
                n_fail++; $display("FAIL read_valid[%0d]: disp_valid=%b, expected %b", c, disp_valid, exp_v);
            end
            if (exp_v && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                n_checks++;
                if (disp_data !== exp_d) begin
                    n_fail++; $display("FAIL read_data[%0d]: disp_data=%0d, expected %0d", c, disp_data, exp_d);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (disp_data !== 3'd7) begin
                    n_fail++; $display("FAIL read_data_hold: disp_data=%0d, expected 7", disp_data);
                end
            end
            if (c < 8) begin
                disp_req = 1'b1; disp_addr = ADDR_W'(c);
                exp_q.push_back(DATA_W'(c & 7));
            end else begin
                disp_req = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL read_scoreboard_drain: %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_display_priority();
        wr0_req = 1'b1; wr0_addr = 19'd5; wr0_data = 3'd3;
        for (int c = 0; c <= 642; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 640) begin
                n_checks++;
                if (wr0_gnt !== 1'b0 || mem_we !== 1'b0) begin
                    n_fail++; $display("FAIL prio_no_gnt[%0d]: gnt0=%b we=%b, expected 0 0", c, wr0_gnt, mem_we);
                end
            end
            if (c == 641) begin
                n_checks++;
                if (wr0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_en !== 1'b1 ||
                    mem_addr !== 19'd5 || mem_wdata !== 3'd3) begin
                    n_fail++;
                    $display("FAIL prio_gnt_after: gnt0=%b en=%b we=%b addr=%0d wdata=%0d, expected 1 1 1 5 3",
                             wr0_gnt, mem_en, mem_we, mem_addr, mem_wdata);
                end
                wr0_req = 1'b0;
            end
            if (c == 642) begin
                n_checks++;
                if (wr0_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL prio_single_gnt: gnt0=%b, expected 0", wr0_gnt);
                end
            end
            disp_req = (c < 640); disp_addr = ADDR_W'(c);
        end
        set_idle();
    endtask

    task automatic test_round_robin();
        logic exp1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr0_addr = 19'd100; wr0_data = 3'd1;
        wr1_addr = 19'd200; wr1_data = 3'd6;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                exp1 = ((c - 1) % 2) == 1;
                n_checks++;
                if (wr0_gnt !== !exp1 || wr1_gnt !== exp1 || mem_we !== 1'b1 ||
                    mem_addr !== (exp1 ? 19'd200 : 19'd100) ||
                    mem_wdata !== (exp1 ? 3'd6 : 3'd1)) begin
                    n_fail++;
                    $display("FAIL rr_pattern[%0d]: gnt0=%b gnt1=%b addr=%0d wdata=%0d, expected winner wr%0d",
                             c, wr0_gnt, wr1_gnt, mem_addr, mem_wdata, exp1);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (wr0_gnt !== 1'b0 || wr1_gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 19'd200) begin
                    n_fail++;
                    $display("FAIL rr_idle_hold: gnt0=%b gnt1=%b en=%b addr=%0d, expected 0 0 0 200",
                             wr0_gnt, wr1_gnt, mem_en, mem_addr);
                end
            end
            wr0_req = (c < 4); wr1_req = (c < 4);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if (wr1_gnt !== 1'b1 || wr0_gnt !== 1'b0 || mem_addr !== ADDR_W'(19 + c) ||
                    mem_wdata !== DATA_W'(4 + c)) begin
                    n_fail++;
                    $display("FAIL b2b_gnt[%0d]: gnt1=%b addr=%0d wdata=%0d, expected 1 %0d %0d",
                             c, wr1_gnt, mem_addr, mem_wdata, 19 + c, 4 + c);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (wr1_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_end: gnt1=%b, expected 0", wr1_gnt);
                end
            end
            wr1_req = (c < 3); wr1_addr = ADDR_W'(20 + c); wr1_data = DATA_W'(5 + c);
        end
        set_idle();
    endtask

    task automatic test_gate();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (wr1_gnt !== 1'b0 || mem_en !== 1'b0) begin
                    n_fail++; $display("FAIL gate_hold[%0d]: gnt1=%b en=%b, expected 0 0", c, wr1_gnt, mem_en);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (wr1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd30) begin
                    n_fail++;
                    $display("FAIL gate_vblank_gnt: gnt1=%b we=%b addr=%0d, expected 1 1 30",
                             wr1_gnt, mem_we, mem_addr);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (wr1_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL gate_after: gnt1=%b, expected 0", wr1_gnt);
                end
            end
            gate_en = (c < 5); vblank = (c == 4);
            wr1_req = (c < 5); wr1_addr = 19'd30; wr1_data = 3'd6;
        end
        set_idle();
    endtask

    task automatic test_range();
        logic [DATA_W-1:0] exp_d;
        @(negedge clk);
        wr0_req = 1'b1; wr0_addr = ADDR_W'(DEPTH); wr0_data = 3'd1;
        @(negedge clk);
        n_checks++;
        if (wr0_gnt !== 1'b1 || wr_err !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL range_oob: gnt0=%b err=%b en=%b we=%b, expected 1 1 0 0",
                     wr0_gnt, wr_err, mem_en, mem_we);
        end
        wr0_addr = ADDR_W'(DEPTH - 1); wr0_data = 3'd2;
        @(negedge clk);
        n_checks++;
        if (wr0_gnt !== 1'b1 || wr_err !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== ADDR_W'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL range_last: gnt0=%b err=%b en=%b we=%b addr=%0d, expected 1 0 1 1 %0d",
                     wr0_gnt, wr_err, mem_en, mem_we, mem_addr, DEPTH - 1);
        end
        wr0_req = 1'b0;
        disp_req = 1'b1; disp_addr = ADDR_W'(DEPTH - 1);
        exp_q.push_back(3'd2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            disp_req = 1'b0;
            if (c == 1) begin
                n_checks++;
                if (wr_err !== 1'b0) begin
                    n_fail++; $display("FAIL range_err_pulse: err=%b, expected 0", wr_err);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (disp_valid !== 1'b1 || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL range_readback_valid: disp_valid=%b, expected 1", disp_valid);
                end else begin
                    exp_d = exp_q.pop_front();
                    n_checks++;
                    if (disp_data !== exp_d) begin
                        n_fail++;
                        $display("FAIL range_readback_data: disp_data=%0d, expected %0d", disp_data, exp_d);
                    end
                end
            end
        end
        exp_q.delete();
        set_idle();
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_display_priority();
        test_round_robin();
        test_back_to_back();
        test_gate();
        test_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
